// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame constants and baud divider helper
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;
    function automatic int uart_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period counter, tick on the last clock of each DIV-clock period
module uart_baud_counter #(
    parameter int DIV = 234
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == W'(DIV - 1);
    // wrap at the period end; clear pins the count at zero so the next period starts fresh
    always_comb cnt_d = (clear || tick) ? '0 : cnt_q + W'(1);
    // counter register
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with integer baud division
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] data,
    input  logic                      start,
    output logic                      busy,
    output logic                      tx
);
    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [IW-1:0] LAST = IW'(UART_DATA_BITS - 1);
    uart_state_e state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic tx_q, tx_d, busy_q, busy_d, tick;
    assign tx = tx_q;
    assign busy = busy_q;
    uart_baud_counter #(.DIV(DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == IDLE),
        .tick (tick)
    );
    // frame sequencing: each bit advances only at a bit-period end
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (start) begin
                shift_d = data;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
                state_d = START;
            end
            START: if (tick) begin
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                idx_d   = '0;
                state_d = DATA;
            end
            DATA: if (tick) begin
                if (idx_q == LAST) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                end
            end
            STOP: if (tick) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers; reset abandons any frame in flight and parks the line high
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized self-checking bench against a frame-level line model
module tb_uart_transmitter;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
    logic [7:0] data = 8'h00;
    logic start_a, start_b, tx_a, busy_a, tx_b, busy_b;
    int passed = 0, total = 0, div = 234;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    always #5 clk = ~clk;

    uart_transmitter dut_a (
        .clk(clk), .rst(rst), .data(data), .start(start_a), .busy(busy_a), .tx(tx_a)
    );
    uart_transmitter #(.CLK_FREQ(16), .BAUD_RATE(4)) dut_b (
        .clk(clk), .rst(rst), .data(data), .start(start_b), .busy(busy_b), .tx(tx_b)
    );

    // line level of frame slot j: start 0, data LSB first, stop 1
    function automatic logic exp_bit(input logic [7:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return d[j-1];
    endfunction

    // caller has start=1/data=d set before the accepting edge
    task automatic frame(input logic [7:0] d, input bit keep, input int inj_k, input logic [7:0] next_d);
        int bad_tx = 0, bad_busy = 0;
        logic [9:0] ctr = '0;
        logic o_tx = 1'b0, o_busy = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 10 * div; k++) begin
            @(negedge clk);
            o_tx = sel ? tx_b : tx_a;
            o_busy = sel ? busy_b : busy_a;
            if (k < 10 * div) begin
                if (o_tx !== exp_bit(d, k / div)) bad_tx++;
                if (o_busy !== 1'b1) bad_busy++;
                if (k % div == div / 2) ctr[k/div] = o_tx;
            end
            if (k == 0) begin
                if (!keep) start = 1'b0;
                data = next_d;
            end
            if (inj_k >= 0 && k == inj_k) begin
                start = 1'b1;
                data = 8'hFF;
            end
            if (inj_k >= 0 && k == inj_k + 1) start = 1'b0;
        end
        total++;
        if (bad_tx !== 0) $display("FAIL frame_tx %02h: %0d cycles wrong, expected 0", d, bad_tx);
        else passed++;
        total++;
        if (bad_busy !== 0) $display("FAIL frame_busy %02h: %0d cycles low, expected 0", d, bad_busy);
        else passed++;
        total++;
        if (ctr !== {1'b1, d, 1'b0}) $display("FAIL centres %02h: got %b, expected %b", d, ctr, {1'b1, d, 1'b0});
        else passed++;
        total++;
        if (o_busy !== 1'b0) $display("FAIL end_busy %02h: got %b, expected 0", d, o_busy);
        else passed++;
        total++;
        if (o_tx !== 1'b1) $display("FAIL end_tx %02h: got %b, expected 1", d, o_tx);
        else passed++;
    endtask

    task automatic idle_check(input int n, input string name);
        int bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if ((sel ? tx_b : tx_a) !== 1'b1 || (sel ? busy_b : busy_a) !== 1'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL %s: %0d non-idle cycles, expected 0", name, bad);
        else passed++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({tx_a, busy_a} !== 2'b10) $display("FAIL reset_a: got tx/busy %b, expected 10", {tx_a, busy_a});
        else passed++;
        total++;
        if ({tx_b, busy_b} !== 2'b10) $display("FAIL reset_b: got tx/busy %b, expected 10", {tx_b, busy_b});
        else passed++;
        rst = 1'b0;
        sel = 1'b1;
        div = 4;
        data = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if ({tx_b, busy_b} !== 2'b10) $display("FAIL async_reset: got tx/busy %b, expected 10", {tx_b, busy_b});
        else passed++;
        idle_check(5, "reset_hold");
        rst = 1'b0;
    endtask

    task automatic test_single_default;
        sel = 1'b0;
        div = 234;
        data = 8'h55;
        start = 1'b1;
        frame(8'h55, 1'b0, -1, 8'h00);
    endtask

    task automatic test_a3;
        sel = 1'b1;
        div = 4;
        data = 8'hA3;
        start = 1'b1;
        frame(8'hA3, 1'b0, -1, 8'h00);
    endtask

    task automatic test_ignored;
        sel = 1'b0;
        div = 234;
        data = 8'h00;
        start = 1'b1;
        frame(8'h00, 1'b0, 100, 8'h00);
        idle_check(30, "no_second_frame");
    endtask

    task automatic test_back_to_back;
        sel = 1'b1;
        div = 4;
        data = 8'h41;
        start = 1'b1;
        frame(8'h41, 1'b1, -1, 8'h42);
        frame(8'h42, 1'b0, -1, 8'h00);
        idle_check(10, "b2b_idle");
    endtask

    task automatic test_random;
        logic [7:0] d;
        sel = 1'b1;
        div = 4;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            data = d;
            start = 1'b1;
            frame(d, 1'b0, -1, 8'($urandom));
        end
    endtask

    task automatic test_mid_reset;
        sel = 1'b1;
        div = 4;
        data = 8'hB6;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (17) @(posedge clk);
        total++;
        #1;
        if (tx_b !== 1'b0) $display("FAIL mid_bit3: got %b, expected 0", tx_b);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({tx_b, busy_b} !== 2'b10) $display("FAIL mid_reset: got tx/busy %b, expected 10", {tx_b, busy_b});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        idle_check(100, "after_mid_reset");
    endtask

    task automatic test_release_with_start;
        sel = 1'b1;
        div = 4;
        rst = 1'b1;
        data = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame(8'h3C, 1'b0, -1, 8'h00);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_single_default;
        test_a3;
        test_ignored;
        test_back_to_back;
        test_random;
        test_mid_reset;
        test_release_with_start;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
